// File: rtl/router_nport_if.sv
// Router stream interface: one input packet stream plus NUM_PORTS show-ahead output channels.
// master = packet source / channel readers, slave = router.
interface router_nport_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ERRCNT_W  = 8
);
  logic [DATA_W-1:0]           data_in;
  logic                        pkt_valid;
  logic                        busy;
  logic [NUM_PORTS-1:0]        read_enb;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS-1:0]        vld_out;
  logic                        err;
  logic                        drop;
  logic [NUM_PORTS-1:0]        soft_rst;
  logic [ERRCNT_W-1:0]         err_count;

  modport master (
    output data_in, pkt_valid, read_enb,
    input  busy, data_out, vld_out, err, drop, soft_rst, err_count
  );

  modport slave (
    input  data_in, pkt_valid, read_enb,
    output busy, data_out, vld_out, err, drop, soft_rst, err_count
  );
endinterface

// File: rtl/router_nport.sv
// N-port packet router: header-addressed input FSM feeding per-channel show-ahead FIFOs
// with XOR parity check, invalid-address drop and per-channel read-timeout flush.
module router_nport #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic           clock,
  input  logic           reset,
  router_nport_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(NUM_PORTS);
  localparam int unsigned LEN_W  = DATA_W - ADDR_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PARITY, CHECK, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   xor_q;
  logic                err_q;
  logic                drop_q;
  logic [ERRCNT_W-1:0] err_cnt;
  logic [NUM_PORTS-1:0] soft_rst_q;

  logic [DATA_W-1:0] mem    [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_PORTS];
  logic [PTR_W-1:0]  wr_ptr [NUM_PORTS];
  logic [CNT_W-1:0]  count  [NUM_PORTS];
  logic [TMO_W-1:0]  tmo    [NUM_PORTS];

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic                hdr_ok;
  logic [ADDR_W-1:0]   tgt;
  logic                tgt_valid;
  logic [NUM_PORTS-1:0] tgt_hot, full, vld, flush, pop, push;
  logic                busy_c;
  logic                accept;
  logic [NUM_PORTS*DATA_W-1:0] dout;

  assign hdr_addr = bus.data_in[ADDR_W-1:0];
  assign hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
  assign hdr_ok   = ({1'b0, hdr_addr} < (ADDR_W+1)'(NUM_PORTS));

  // In IDLE the target comes from the header on the bus, afterwards from the latched address.
  assign tgt       = (state == IDLE) ? hdr_addr : addr_q;
  assign tgt_valid = (state == IDLE) ? hdr_ok : (state == LOAD || state == PARITY);

  always_comb begin
    tgt_hot = '0;
    full    = '0;
    vld     = '0;
    flush   = '0;
    pop     = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      tgt_hot[i] = tgt_valid && (tgt == ADDR_W'(i));
      full[i]    = (count[i] == CNT_W'(FIFO_DEPTH));
      vld[i]     = (count[i] != '0);
      flush[i]   = vld[i] && !bus.read_enb[i] && (tmo[i] == TMO_W'(TIMEOUT - 1));
      pop[i]     = vld[i] && bus.read_enb[i];
    end
  end

  assign busy_c = reset || (state == CHECK) ||
                  (bus.pkt_valid && (|(tgt_hot & (full | flush))));
  assign accept = bus.pkt_valid && !busy_c;
  assign push   = accept ? tgt_hot : '0;

  // Show-ahead heads, forced to zero on empty channels.
  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (vld[i]) dout[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.data_in;
    end
  end

  // Pointers, occupancy and timeout counters; a timeout empties the channel outright.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        tmo[i]    <= '0;
      end
      soft_rst_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (flush[i]) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          count[i]  <= '0;
          tmo[i]    <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
          tmo[i]   <= (vld[i] && !bus.read_enb[i]) ? tmo[i] + TMO_W'(1) : '0;
        end
      end
      soft_rst_q <= flush;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      xor_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          len_q <= hdr_len;
          if (hdr_ok) begin
            addr_q <= hdr_addr;
            xor_q  <= bus.data_in;
            state  <= (hdr_len == '0) ? PARITY : LOAD;
          end else begin
            drop_q <= 1'b1;
            state  <= DROP;
          end
        end
        LOAD: if (accept) begin
          xor_q <= xor_q ^ bus.data_in;
          len_q <= len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state <= PARITY;
        end
        PARITY: if (accept) begin
          err_q <= (bus.data_in != xor_q);
          if ((bus.data_in != xor_q) && (err_cnt != '1)) err_cnt <= err_cnt + ERRCNT_W'(1);
          state <= CHECK;
        end
        CHECK: state <= IDLE;
        // Drop swallows the remaining len payload words plus the parity word.
        DROP: if (accept) begin
          if (len_q == '0) state <= IDLE;
          else             len_q <= len_q - LEN_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.data_out  = dout;
  assign bus.vld_out   = vld;
  assign bus.err       = err_q;
  assign bus.drop      = drop_q;
  assign bus.soft_rst  = soft_rst_q;
  assign bus.err_count = err_cnt;
endmodule

// File: tb/tb_router_nport.sv
// Bench for router_nport: directed cycle vectors, hand sequences for timeout / reset /
// backpressure, and a randomized run against a queue-based reference model.
module tb_router_nport;
  localparam int unsigned DW = 8, NP = 3, DEPTH = 16, TMO = 30, EW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  router_nport_if #(.DATA_W(DW), .NUM_PORTS(NP), .ERRCNT_W(EW)) bus  ();
  router_nport_if #(.DATA_W(DW), .NUM_PORTS(NP), .ERRCNT_W(EW)) bus4 ();

  router_nport #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .ERRCNT_W(EW))
    dut  (.clock(clock), .reset(reset), .bus(bus));
  router_nport #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(4), .TIMEOUT(TMO), .ERRCNT_W(EW))
    dut4 (.clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [7:0]  din;
    logic [2:0]  rd;
    logic        busy;
    logic [2:0]  vld;
    logic        err;
    logic        drop;
    logic [23:0] dout;
    logic [7:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic pv, input logic [7:0] din, input logic [2:0] rd,
                              input logic busy, input logic [2:0] vld, input logic err,
                              input logic drop, input int dport, input logic [7:0] dval,
                              input logic [7:0] ecnt);
    vec_t v;
    v.pv = pv; v.din = din; v.rd = rd; v.busy = busy; v.vld = vld;
    v.err = err; v.drop = drop; v.ecnt = ecnt;
    v.dout = 24'(dval) << (8 * dport);
    return v;
  endfunction

  // Present one word and hold it until the router accepts it.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    bus.data_in = d;
    bus.pkt_valid = 1'b1;
    #1;
    while (bus.busy && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (bus.busy) chk("send_word_stuck", 64'(bus.busy), 64'(0));
    @(negedge clock);
    bus.pkt_valid = 1'b0;
  endtask

  // Random-run reference model types and state.
  typedef struct {
    logic [7:0] d;
    int         port;
    bit         first;
    bit         last;
    bit         bad;
  } tw_t;

  tw_t        txq[$];
  logic [7:0] mq[NP][$];
  int         idle_cnt[NP];

  task automatic gen_pkt();
    int port, len;
    bit bad;
    logic [7:0] x, w;
    tw_t e;
    port = $urandom_range(0, 3);
    len  = $urandom_range(0, 9);
    bad  = ($urandom_range(0, 3) == 0);
    x = {6'(len), 2'(port)};
    e.port = port; e.bad = bad;
    e.d = x; e.first = 1; e.last = 0; txq.push_back(e);
    for (int k = 0; k < len; k++) begin
      w = 8'($urandom_range(0, 255));
      x = x ^ w;
      e.d = w; e.first = 0; e.last = 0; txq.push_back(e);
    end
    e.d = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    e.first = 0; e.last = 1; txq.push_back(e);
  endtask

  vec_t vt[$];
  logic [7:0] w4 [6] = '{8'h10, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h14};
  logic [7:0] rp [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};

  initial begin
    int t0, sent, npk, drain, rdp, exp_ecnt, tgt;
    bit present, exp_busy, in_check, exp_err, exp_drop, acc, was;
    logic [2:0] exp_srst, flushing, ev;
    logic [23:0] ed;
    tw_t w;

    bus.data_in = '0;  bus.pkt_valid = 1'b0;  bus.read_enb = '0;
    bus4.data_in = '0; bus4.pkt_valid = 1'b0; bus4.read_enb = '0;

    // Directed cycle vectors: basic routing, parity error, invalid address.
    vt.push_back(mk(1, 8'h0D, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 0));
    vt.push_back(mk(1, 8'h11, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h22, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h33, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h0D, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(0, 8'h00, 3'b000, 1, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h11, 0));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h22, 0));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h33, 0));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 0));
    vt.push_back(mk(1, 8'h0D, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 0));
    vt.push_back(mk(1, 8'h11, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h22, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h33, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(1, 8'h0C, 3'b000, 0, 3'b010, 0, 0, 1, 8'h0D, 0));
    vt.push_back(mk(0, 8'h00, 3'b000, 1, 3'b010, 1, 0, 1, 8'h0D, 1));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h0D, 1));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h11, 1));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h22, 1));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h33, 1));
    vt.push_back(mk(0, 8'h00, 3'b010, 0, 3'b010, 0, 0, 1, 8'h0C, 1));
    vt.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'h07, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'hAA, 3'b000, 0, 3'b000, 0, 1, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'hBB, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));
    vt.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'h02, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));
    vt.push_back(mk(1, 8'h02, 3'b000, 0, 3'b100, 0, 0, 2, 8'h02, 1));
    vt.push_back(mk(0, 8'h00, 3'b000, 1, 3'b100, 0, 0, 2, 8'h02, 1));
    vt.push_back(mk(0, 8'h00, 3'b100, 0, 3'b100, 0, 0, 2, 8'h02, 1));
    vt.push_back(mk(0, 8'h00, 3'b100, 0, 3'b100, 0, 0, 2, 8'h02, 1));
    vt.push_back(mk(0, 8'h00, 3'b000, 0, 3'b000, 0, 0, 0, 8'h00, 1));

    @(negedge clock); @(negedge clock);
    chk("reset_state",
        64'({bus.busy, bus.vld_out, bus.err, bus.drop, bus.soft_rst, bus.data_out, bus.err_count}),
        64'({1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 24'h0, 8'h0}));
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      bus.pkt_valid = vt[i].pv;
      bus.data_in   = vt[i].din;
      bus.read_enb  = vt[i].rd;
      #1;
      chk($sformatf("vec%0d", i),
          64'({bus.busy, bus.vld_out, bus.err, bus.drop, bus.data_out, bus.err_count}),
          64'({vt[i].busy, vt[i].vld, vt[i].err, vt[i].drop, vt[i].dout, vt[i].ecnt}));
      @(negedge clock);
    end
    bus.pkt_valid = 1'b0; bus.read_enb = '0;

    // Timeout: len=0 packet on port 2 left unread.
    send_word(8'h02);
    chk("tmo_vld_rise", 64'(bus.vld_out[2]), 64'(1));
    t0 = cyc;
    send_word(8'h02);
    while (!bus.soft_rst[2] && (cyc - t0) < 60) @(negedge clock);
    chk("tmo_cycles", 64'(cyc - t0), 64'(TMO));
    chk("tmo_flushed", 64'(bus.vld_out[2]), 64'(0));
    @(negedge clock);
    chk("tmo_pulse_one_cycle", 64'(bus.soft_rst), 64'(0));

    // Reset after the second payload word.
    send_word(8'h0D); send_word(8'h11); send_word(8'h22);
    chk("rst_pre_vld", 64'(bus.vld_out), 64'(3'b010));
    reset = 1'b1;
    @(negedge clock); #1;
    chk("rst_during", 64'({bus.busy, bus.vld_out, bus.err_count}), 64'({1'b1, 3'b000, 8'h00}));
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) send_word(rp[j]);
    @(negedge clock);
    chk("rst_next_vld", 64'(bus.vld_out), 64'(3'b001));
    for (int j = 0; j < 5; j++) begin
      bus.read_enb = 3'b001; #1;
      chk($sformatf("rst_next_rd%0d", j), 64'(bus.data_out[7:0]), 64'(rp[j]));
      @(negedge clock);
    end
    bus.read_enb = '0; #1;
    chk("rst_next_empty", 64'(bus.vld_out), 64'(0));
    @(negedge clock);

    // Backpressure on the 4-deep instance.
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      bus4.pkt_valid = (sent < 6); bus4.data_in = (sent < 6) ? w4[sent] : 8'h00;
      bus4.read_enb = '0; #1;
      if (bus4.pkt_valid && !bus4.busy) sent++;
      @(negedge clock);
    end
    bus4.pkt_valid = 1'b1; bus4.data_in = w4[sent]; #1;
    chk("bp_sent_until_full", 64'(sent), 64'(4));
    chk("bp_busy_full", 64'(bus4.busy), 64'(1));
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 3; c++) begin
        bus4.pkt_valid = (sent < 6); bus4.data_in = (sent < 6) ? w4[sent] : 8'h00;
        bus4.read_enb = (c == 0) ? 3'b001 : 3'b000; #1;
        if (c == 0) chk($sformatf("bp_pop%0d", p),
                        64'({bus4.vld_out[0], bus4.data_out[7:0]}), 64'({1'b1, w4[p]}));
        if (bus4.pkt_valid && !bus4.busy) sent++;
        @(negedge clock);
      end
      chk($sformatf("bp_sent_after_pop%0d", p), 64'(sent), 64'((p + 5 < 6) ? p + 5 : 6));
    end
    bus4.pkt_valid = 1'b0; bus4.read_enb = '0; #1;
    chk("bp_drained", 64'(bus4.vld_out), 64'(0));
    @(negedge clock);

    // Randomized run against the queue model.
    reset = 1'b1; bus.pkt_valid = 1'b0; bus.read_enb = '0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < int'(NP); i++) begin mq[i].delete(); idle_cnt[i] = 0; end
    txq.delete();
    npk = 0; drain = 0; exp_ecnt = 0;
    in_check = 0; exp_err = 0; exp_drop = 0; exp_srst = '0;
    t0 = cyc;
    while (drain < 60 && (cyc - t0) < 20000) begin
      if (txq.size() == 0 && npk < 150) begin gen_pkt(); npk++; end
      rdp = (txq.size() == 0) ? 100 : ((((cyc - t0) / 200) % 3 == 0) ? 5 :
                                      ((((cyc - t0) / 200) % 3 == 1) ? 40 : 90));
      present = (txq.size() > 0) && ($urandom_range(0, 99) < 85);
      bus.pkt_valid = present;
      bus.data_in = (txq.size() > 0) ? txq[0].d : 8'h00;
      for (int i = 0; i < int'(NP); i++) bus.read_enb[i] = ($urandom_range(0, 99) < rdp);
      #1;
      for (int i = 0; i < int'(NP); i++)
        flushing[i] = (mq[i].size() > 0) && !bus.read_enb[i] && (idle_cnt[i] == int'(TMO) - 1);
      tgt = (txq.size() > 0) ? txq[0].port : int'(NP);
      exp_busy = in_check ||
                 (present && tgt < int'(NP) && (mq[tgt].size() == int'(DEPTH) || flushing[tgt]));
      ev = '0; ed = '0;
      for (int i = 0; i < int'(NP); i++) if (mq[i].size() > 0) begin
        ev[i] = 1'b1; ed[i*8 +: 8] = mq[i][0];
      end
      chk("rand_busy", 64'(bus.busy), 64'(exp_busy));
      chk("rand_out", 64'({bus.vld_out, bus.data_out}), 64'({ev, ed}));
      chk("rand_pulse", 64'({bus.err, bus.drop, bus.soft_rst}), 64'({exp_err, exp_drop, exp_srst}));

      acc = present && !exp_busy;
      exp_err = 0; exp_drop = 0; exp_srst = '0; in_check = 0;
      for (int i = 0; i < int'(NP); i++) begin
        was = (mq[i].size() > 0);
        if (flushing[i]) begin
          mq[i].delete(); idle_cnt[i] = 0; exp_srst[i] = 1'b1;
        end else begin
          if (bus.read_enb[i] && was) void'(mq[i].pop_front());
          idle_cnt[i] = (was && !bus.read_enb[i]) ? idle_cnt[i] + 1 : 0;
        end
      end
      if (acc) begin
        w = txq.pop_front();
        if (w.port < int'(NP)) begin
          mq[w.port].push_back(w.d);
          if (w.last) begin
            in_check = 1; exp_err = w.bad;
            if (w.bad && exp_ecnt < 255) exp_ecnt++;
          end
        end else if (w.first) exp_drop = 1;
      end
      if (npk >= 150 && txq.size() == 0) drain++;
      @(negedge clock);
    end
    chk("rand_finished", 64'(drain), 64'(60));
    chk("rand_errcnt", 64'(bus.err_count), 64'(exp_ecnt));
    chk("rand_empty", 64'(bus.vld_out), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected earlier end", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
